hicore_icache: RTL and testbench

Blocking, direct-mapped instruction cache between the fetch stage's instruction ICB master and the system memory ICB. It returns one 32-bit instruction per accepted read, in order and one at a time, and refills whole lines on a miss. It also honours fetch-stage flush/branch, which discards the response owed for the current request, and `fence_i`, which invalidates every line.

---
 rtl/hicore_icache.sv | 188 ++++++++++++++++++
 tb/tb_hicore_icache.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hicore_icache.sv
// rtl/hicore_icache.sv - blocking direct-mapped instruction cache with whole-line refill
module hicore_icache #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_icb_cmd_valid,
  output logic        icache_icb_cmd_ready,
  input  logic        icache_icb_cmd_read,
  input  logic [31:0] icache_icb_cmd_addr,
  input  logic [31:0] icache_icb_cmd_wdata,
  input  logic [3:0]  icache_icb_cmd_wmask,
  output logic        icache_icb_rsp_valid,
  input  logic        icache_icb_rsp_ready,
  output logic [31:0] icache_icb_rsp_rdata,
  output logic        icache_icb_rsp_err,
  output logic        mem_icb_cmd_valid,
  input  logic        mem_icb_cmd_ready,
  output logic        mem_icb_cmd_read,
  output logic [31:0] mem_icb_cmd_addr,
  output logic [31:0] mem_icb_cmd_wdata,
  output logic [3:0]  mem_icb_cmd_wmask,
  input  logic        mem_icb_rsp_valid,
  output logic        mem_icb_rsp_ready,
  input  logic [31:0] mem_icb_rsp_rdata,
  input  logic        mem_icb_rsp_err,
  input  logic        flush,
  input  logic        fence_i
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {IDLE, RESP, REFILL} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [OFF_W:0]     ccnt_q, ccnt_d;
  logic [OFF_W-1:0]   rcnt_q, rcnt_d;
  logic               sticky_q, sticky_d;
  logic               drop_q, drop_d;
  logic               fence_q, fence_d;
  logic [SETS-1:0]    valid_q, valid_d;
  logic [31:0]        lbuf_q [LINE_WORDS];
  logic [31:0]        lbuf_d [LINE_WORDS];
  logic [TAG_W-1:0]   tag_q [SETS];
  logic [31:0]        data_q [SETS][LINE_WORDS];
  logic               line_we;

  logic [IDX_W-1:0]   req_idx, cur_idx;
  logic [OFF_W-1:0]   req_off, cur_off;
  logic [TAG_W-1:0]   req_tag, cur_tag;
  logic               accept, hit, issuing, mem_rsp_fire, refill_done;
  logic               unused_ok;

  assign req_idx = icache_icb_cmd_addr[OFF_W+2 +: IDX_W];
  assign req_off = icache_icb_cmd_addr[2 +: OFF_W];
  assign req_tag = icache_icb_cmd_addr[31 -: TAG_W];
  assign cur_idx = addr_q[OFF_W+2 +: IDX_W];
  assign cur_off = addr_q[2 +: OFF_W];
  assign cur_tag = addr_q[31 -: TAG_W];

  assign icache_icb_cmd_ready = ((state_q == IDLE) || (state_q == RESP && icache_icb_rsp_ready))
                                && !flush && !fence_q;
  assign accept       = icache_icb_cmd_valid && icache_icb_cmd_ready;
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // The command counter's MSB sets once all LINE_WORDS reads have been issued.
  assign issuing      = (state_q == REFILL) && !ccnt_q[OFF_W];
  assign mem_rsp_fire = (state_q == REFILL) && mem_icb_rsp_valid;
  assign refill_done  = mem_rsp_fire && (&rcnt_q);

  assign icache_icb_rsp_valid = (state_q == RESP);
  assign icache_icb_rsp_rdata = rdata_q;
  assign icache_icb_rsp_err   = err_q;
  assign mem_icb_cmd_valid    = issuing;
  assign mem_icb_cmd_addr     = issuing ? {addr_q[31:OFF_W+2], ccnt_q[OFF_W-1:0], 2'b00} : 32'h0;
  assign mem_icb_cmd_read     = 1'b1;
  assign mem_icb_cmd_wdata    = 32'h0;
  assign mem_icb_cmd_wmask    = 4'h0;
  assign mem_icb_rsp_ready    = 1'b1;

  assign unused_ok = ^{icache_icb_cmd_read, icache_icb_cmd_wdata, icache_icb_cmd_wmask,
                       icache_icb_cmd_addr[1:0], addr_q[1:0]};

  // Next-state: lookup on accept, refill sequencing, flush drop and fence handling.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    ccnt_d   = ccnt_q;
    rcnt_d   = rcnt_q;
    sticky_d = sticky_q;
    drop_d   = drop_q;
    fence_d  = fence_q;
    valid_d  = valid_q;
    lbuf_d   = lbuf_q;
    line_we  = 1'b0;

    if (issuing && mem_icb_cmd_ready) ccnt_d = ccnt_q + 1'b1;
    if (mem_rsp_fire) begin
      lbuf_d[rcnt_q] = mem_icb_rsp_rdata;
      sticky_d       = sticky_q | mem_icb_rsp_err;
      rcnt_d         = rcnt_q + 1'b1;
    end

    case (state_q)
      RESP: begin
        if (flush || icache_icb_rsp_ready) state_d = IDLE;
      end
      REFILL: begin
        if (flush) drop_d = 1'b1;
        if (refill_done) begin
          line_we = !sticky_d;
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            rdata_d = lbuf_d[cur_off];
            err_d   = sticky_d;
          end
        end
      end
      default: ;
    endcase

    if (accept) begin
      addr_d   = icache_icb_cmd_addr;
      ccnt_d   = '0;
      rcnt_d   = '0;
      sticky_d = 1'b0;
      drop_d   = 1'b0;
      if (hit) begin
        state_d = RESP;
        rdata_d = data_q[req_idx][req_off];
        err_d   = 1'b0;
      end else begin
        state_d = REFILL;
      end
    end

    // Line write lands before any invalidate so a fence racing a refill wins.
    if (line_we) valid_d[cur_idx] = 1'b1;
    if (state_q == IDLE && (fence_i || fence_q)) valid_d = '0;

    if (state_q == IDLE) fence_d = 1'b0;
    else if (fence_i)    fence_d = 1'b1;
  end

  // Control state and valid bits; reset abandons any refill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      ccnt_q   <= '0;
      rcnt_q   <= '0;
      sticky_q <= 1'b0;
      drop_q   <= 1'b0;
      fence_q  <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      ccnt_q   <= ccnt_d;
      rcnt_q   <= rcnt_d;
      sticky_q <= sticky_d;
      drop_q   <= drop_d;
      fence_q  <= fence_d;
      valid_q  <= valid_d;
    end
  end

  // Tag/data arrays and the refill line buffer carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    lbuf_q <= lbuf_d;
    if (line_we) begin
      tag_q[cur_idx]  <= cur_tag;
      data_q[cur_idx] <= lbuf_d;
    end
  end
endmodule

// File: tb/tb_hicore_icache.sv
// tb/tb_hicore_icache.sv - scoreboard bench for hicore_icache
module tb_hicore_icache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_icb_cmd_valid = 1'b0;
  logic        icache_icb_cmd_ready;
  logic        icache_icb_cmd_read = 1'b1;
  logic [31:0] icache_icb_cmd_addr = '0;
  logic [31:0] icache_icb_cmd_wdata = '0;
  logic [3:0]  icache_icb_cmd_wmask = '0;
  logic        icache_icb_rsp_valid;
  logic        icache_icb_rsp_ready = 1'b1;
  logic [31:0] icache_icb_rsp_rdata;
  logic        icache_icb_rsp_err;
  logic        mem_icb_cmd_valid;
  logic        mem_icb_cmd_ready = 1'b1;
  logic        mem_icb_cmd_read;
  logic [31:0] mem_icb_cmd_addr;
  logic [31:0] mem_icb_cmd_wdata;
  logic [3:0]  mem_icb_cmd_wmask;
  logic        mem_icb_rsp_valid = 1'b0;
  logic        mem_icb_rsp_ready;
  logic [31:0] mem_icb_rsp_rdata = '0;
  logic        mem_icb_rsp_err = 1'b0;
  logic        flush = 1'b0;
  logic        fence_i = 1'b0;

  int          nvec = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [32:0] exp_q [$];
  logic [31:0] mem_log [$];
  int          mem_cyc [$];

  hicore_icache dut (
    .clk(clk), .rst_n(rst_n),
    .icache_icb_cmd_valid(icache_icb_cmd_valid), .icache_icb_cmd_ready(icache_icb_cmd_ready),
    .icache_icb_cmd_read(icache_icb_cmd_read), .icache_icb_cmd_addr(icache_icb_cmd_addr),
    .icache_icb_cmd_wdata(icache_icb_cmd_wdata), .icache_icb_cmd_wmask(icache_icb_cmd_wmask),
    .icache_icb_rsp_valid(icache_icb_rsp_valid), .icache_icb_rsp_ready(icache_icb_rsp_ready),
    .icache_icb_rsp_rdata(icache_icb_rsp_rdata), .icache_icb_rsp_err(icache_icb_rsp_err),
    .mem_icb_cmd_valid(mem_icb_cmd_valid), .mem_icb_cmd_ready(mem_icb_cmd_ready),
    .mem_icb_cmd_read(mem_icb_cmd_read), .mem_icb_cmd_addr(mem_icb_cmd_addr),
    .mem_icb_cmd_wdata(mem_icb_cmd_wdata), .mem_icb_cmd_wmask(mem_icb_cmd_wmask),
    .mem_icb_rsp_valid(mem_icb_rsp_valid), .mem_icb_rsp_ready(mem_icb_rsp_ready),
    .mem_icb_rsp_rdata(mem_icb_rsp_rdata), .mem_icb_rsp_err(mem_icb_rsp_err),
    .flush(flush), .fence_i(fence_i)
  );

  always #5 clk = ~clk;

  // Zero-wait memory: word = address, response one cycle after its command.
  always @(posedge clk) begin
    if (rst_n && mem_icb_cmd_valid && mem_icb_cmd_ready) begin
      mem_log.push_back(mem_icb_cmd_addr);
      mem_cyc.push_back(cyc);
    end
    if (!rst_n) begin
      mem_icb_rsp_valid <= 1'b0;
    end else begin
      mem_icb_rsp_valid <= mem_icb_cmd_valid && mem_icb_cmd_ready;
      mem_icb_rsp_rdata <= mem_icb_cmd_addr;
      mem_icb_rsp_err   <= mem_icb_cmd_valid && (mem_icb_cmd_addr == err_addr);
    end
    cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1);
  end

  task automatic fetch(input logic [31:0] a, output logic [31:0] rd, output logic er,
                       output int lat, output int acc);
    int t;
    lat = -1; rd = '0; er = 1'b0; acc = -1;
    @(negedge clk);
    icache_icb_cmd_valid = 1'b1; icache_icb_cmd_addr = a; icache_icb_rsp_ready = 1'b1;
    t = 0;
    while (!icache_icb_cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!icache_icb_cmd_ready) begin icache_icb_cmd_valid = 1'b0; return; end
    acc = cyc;
    @(negedge clk);
    icache_icb_cmd_valid = 1'b0;
    t = 0;
    while (!icache_icb_rsp_valid && t < 50) begin @(negedge clk); t++; end
    if (icache_icb_rsp_valid) begin
      rd = icache_icb_rsp_rdata; er = icache_icb_rsp_err; lat = cyc - acc;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    nvec++; if (icache_icb_cmd_ready !== 1'b1) begin nfail++; $display("FAIL rst_cmd_ready actual %b required 1", icache_icb_cmd_ready); end
    nvec++; if (icache_icb_rsp_valid !== 1'b0) begin nfail++; $display("FAIL rst_rsp_valid actual %b required 0", icache_icb_rsp_valid); end
    nvec++; if (icache_icb_rsp_rdata !== 32'h0) begin nfail++; $display("FAIL rst_rdata actual %h required 0", icache_icb_rsp_rdata); end
    nvec++; if (icache_icb_rsp_err !== 1'b0) begin nfail++; $display("FAIL rst_err actual %b required 0", icache_icb_rsp_err); end
    nvec++; if (mem_icb_cmd_valid !== 1'b0) begin nfail++; $display("FAIL rst_mem_valid actual %b required 0", mem_icb_cmd_valid); end
    nvec++; if (mem_icb_cmd_addr !== 32'h0) begin nfail++; $display("FAIL rst_mem_addr actual %h required 0", mem_icb_cmd_addr); end
  endtask

  task automatic test_cold_miss_hit;
    logic [31:0] rd; logic er; int lat, acc; logic [32:0] e;
    mem_log.delete(); mem_cyc.delete();
    exp_q.push_back({1'b0, 32'h8000_0010});
    fetch(32'h8000_0010, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e) begin nfail++; $display("FAIL miss_data actual %h required %h", {er, rd}, e); end
    nvec++; if (lat !== 6) begin nfail++; $display("FAIL miss_latency actual %0d required 6", lat); end
    nvec++; if (mem_log.size() !== 4) begin nfail++; $display("FAIL miss_mem_count actual %0d required 4", mem_log.size()); end
    for (int i = 0; i < 4 && i < mem_log.size(); i++) begin
      nvec++; if (mem_log[i] !== 32'h8000_0010 + 32'(4 * i)) begin nfail++; $display("FAIL miss_mem_addr%0d actual %h required %h", i, mem_log[i], 32'h8000_0010 + 32'(4 * i)); end
      nvec++; if (mem_cyc[i] !== acc + 1 + i) begin nfail++; $display("FAIL miss_mem_cycle%0d actual %0d required %0d", i, mem_cyc[i], acc + 1 + i); end
    end
    exp_q.push_back({1'b0, 32'h8000_0014});
    fetch(32'h8000_0014, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e) begin nfail++; $display("FAIL hit_data actual %h required %h", {er, rd}, e); end
    nvec++; if (lat !== 1) begin nfail++; $display("FAIL hit_latency actual %0d required 1", lat); end
    nvec++; if (mem_log.size() !== 4) begin nfail++; $display("FAIL hit_mem_traffic actual %0d required 4", mem_log.size()); end
  endtask

  task automatic test_back_to_back;
    logic [32:0] e;
    mem_log.delete();
    icache_icb_rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = exp_q.pop_front();
        nvec++; if (icache_icb_rsp_valid !== 1'b1) begin nfail++; $display("FAIL b2b_valid%0d actual %b required 1", k, icache_icb_rsp_valid); end
        nvec++; if ({icache_icb_rsp_err, icache_icb_rsp_rdata} !== e) begin nfail++; $display("FAIL b2b_data%0d actual %h required %h", k, {icache_icb_rsp_err, icache_icb_rsp_rdata}, e); end
      end
      if (k < 4) begin
        icache_icb_cmd_valid = 1'b1;
        icache_icb_cmd_addr  = 32'h8000_0010 + 32'(4 * k);
        exp_q.push_back({1'b0, 32'h8000_0010 + 32'(4 * k)});
        nvec++; if (icache_icb_cmd_ready !== 1'b1) begin nfail++; $display("FAIL b2b_ready%0d actual %b required 1", k, icache_icb_cmd_ready); end
      end else begin
        icache_icb_cmd_valid = 1'b0;
      end
    end
    nvec++; if (mem_log.size() !== 0) begin nfail++; $display("FAIL b2b_mem_traffic actual %0d required 0", mem_log.size()); end
  endtask

  task automatic test_refill_error;
    logic [31:0] rd; logic er; int lat, acc; logic [32:0] e;
    mem_log.delete();
    err_addr = 32'h8000_0108;
    exp_q.push_back({1'b1, 32'h8000_0104});
    fetch(32'h8000_0104, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e) begin nfail++; $display("FAIL err_first actual %h required %h", {er, rd}, e); end
    err_addr = 32'hFFFF_FFFF;
    exp_q.push_back({1'b0, 32'h8000_0104});
    fetch(32'h8000_0104, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e) begin nfail++; $display("FAIL err_repeat_data actual %h required %h", {er, rd}, e); end
    nvec++; if (lat !== 6) begin nfail++; $display("FAIL err_repeat_latency actual %0d required 6", lat); end
    nvec++; if (mem_log.size() !== 8) begin nfail++; $display("FAIL err_refetch_count actual %0d required 8", mem_log.size()); end
    exp_q.push_back({1'b0, 32'h8000_010C});
    fetch(32'h8000_010C, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e || lat !== 1) begin nfail++; $display("FAIL err_clean_hit actual %h/%0d required %h/1", {er, rd}, lat, e); end
  endtask

  task automatic test_flush_refill;
    logic [31:0] rd; logic er; int lat, acc, seen; logic [32:0] e;
    mem_log.delete();
    @(negedge clk);
    icache_icb_cmd_valid = 1'b1; icache_icb_cmd_addr = 32'h8000_0200; icache_icb_rsp_ready = 1'b1;
    nvec++; if (icache_icb_cmd_ready !== 1'b1) begin nfail++; $display("FAIL flush_accept actual %b required 1", icache_icb_cmd_ready); end
    @(negedge clk); icache_icb_cmd_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); flush = 1'b0;
      if (icache_icb_rsp_valid) seen++;
    end
    nvec++; if (seen !== 0) begin nfail++; $display("FAIL flush_no_rsp actual %0d required 0", seen); end
    nvec++; if (mem_log.size() !== 4) begin nfail++; $display("FAIL flush_mem_count actual %0d required 4", mem_log.size()); end
    exp_q.push_back({1'b0, 32'h8000_0208});
    fetch(32'h8000_0208, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e) begin nfail++; $display("FAIL flush_hit_data actual %h required %h", {er, rd}, e); end
    nvec++; if (lat !== 1) begin nfail++; $display("FAIL flush_hit_latency actual %0d required 1", lat); end
  endtask

  task automatic test_fence;
    logic [31:0] rd; logic er; int lat, acc; logic [32:0] e;
    @(negedge clk);
    icache_icb_rsp_ready = 1'b0;
    icache_icb_cmd_valid = 1'b1; icache_icb_cmd_addr = 32'h8000_0014;
    exp_q.push_back({1'b0, 32'h8000_0014});
    @(negedge clk);
    icache_icb_cmd_valid = 1'b0; fence_i = 1'b1;
    nvec++; if (icache_icb_rsp_valid !== 1'b1) begin nfail++; $display("FAIL fence_in_resp actual %b required 1", icache_icb_rsp_valid); end
    @(negedge clk);
    fence_i = 1'b0; icache_icb_rsp_ready = 1'b1;
    nvec++; if (icache_icb_cmd_ready !== 1'b0) begin nfail++; $display("FAIL fence_ready_resp actual %b required 0", icache_icb_cmd_ready); end
    e = exp_q.pop_front();
    nvec++; if ({icache_icb_rsp_err, icache_icb_rsp_rdata} !== e) begin nfail++; $display("FAIL fence_resp_data actual %h required %h", {icache_icb_rsp_err, icache_icb_rsp_rdata}, e); end
    @(negedge clk);
    nvec++; if (icache_icb_cmd_ready !== 1'b0) begin nfail++; $display("FAIL fence_ready_idle actual %b required 0", icache_icb_cmd_ready); end
    @(negedge clk);
    nvec++; if (icache_icb_cmd_ready !== 1'b1) begin nfail++; $display("FAIL fence_ready_after actual %b required 1", icache_icb_cmd_ready); end
    mem_log.delete();
    exp_q.push_back({1'b0, 32'h8000_0010});
    fetch(32'h8000_0010, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e || lat !== 6) begin nfail++; $display("FAIL fence_miss actual %h/%0d required %h/6", {er, rd}, lat, e); end
    nvec++; if (mem_log.size() !== 4) begin nfail++; $display("FAIL fence_mem_count actual %0d required 4", mem_log.size()); end
  endtask

  task automatic test_reset_mid_refill;
    logic [31:0] rd; logic er; int lat, acc; logic [32:0] e;
    @(negedge clk);
    icache_icb_cmd_valid = 1'b1; icache_icb_cmd_addr = 32'h8000_0300; icache_icb_rsp_ready = 1'b1;
    @(negedge clk); icache_icb_cmd_valid = 1'b0;
    @(negedge clk);
    nvec++; if (mem_icb_cmd_valid !== 1'b1) begin nfail++; $display("FAIL rmid_refilling actual %b required 1", mem_icb_cmd_valid); end
    rst_n = 1'b0;
    #1;
    nvec++; if (mem_icb_cmd_valid !== 1'b0 || mem_icb_cmd_addr !== 32'h0) begin nfail++; $display("FAIL rmid_mem actual %b/%h required 0/0", mem_icb_cmd_valid, mem_icb_cmd_addr); end
    nvec++; if (icache_icb_cmd_ready !== 1'b1 || icache_icb_rsp_valid !== 1'b0) begin nfail++; $display("FAIL rmid_fetch actual %b/%b required 1/0", icache_icb_cmd_ready, icache_icb_rsp_valid); end
    nvec++; if (icache_icb_rsp_rdata !== 32'h0 || icache_icb_rsp_err !== 1'b0) begin nfail++; $display("FAIL rmid_rsp actual %h/%b required 0/0", icache_icb_rsp_rdata, icache_icb_rsp_err); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    mem_log.delete();
    exp_q.push_back({1'b0, 32'h8000_0010});
    fetch(32'h8000_0010, rd, er, lat, acc);
    e = exp_q.pop_front();
    nvec++; if ({er, rd} !== e || lat !== 6) begin nfail++; $display("FAIL rmid_miss actual %h/%0d required %h/6", {er, rd}, lat, e); end
    nvec++; if (mem_log.size() !== 4) begin nfail++; $display("FAIL rmid_mem_count actual %0d required 4", mem_log.size()); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_cold_miss_hit();
    test_back_to_back();
    test_refill_error();
    test_flush_refill();
    test_fence();
    test_reset_mid_refill();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
